// File: rtl/phy_pkg.sv
// Shared definitions for the PHY TX/RX lane schedulers: comma symbol,
// scheduler state encoding and a lane-slice helper.
package phy_pkg;

    // Idle / alignment comma symbol (K28.5 code-group byte).
    localparam logic [7:0] COMMA_BC = 8'hBC;

    // Largest lane count any scheduler in this family supports.
    localparam int MAX_LANES = 8;

    // Scheduler state: ALIGN emits the preamble, RUN arbitrates lane bytes.
    typedef enum logic {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Extract byte 'idx' from a flattened lane bus (lane i on [8i+7:8i]).
    function automatic logic [7:0] lane_byte(input logic [8*MAX_LANES-1:0] bus,
                                             input logic [2:0]             idx);
        return bus[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an optional "hold" on the current
// owner. Shared by the TX scheduler and the RX lane distributor.
module rr_arbiter
    import phy_pkg::*;
#(
    parameter int NUM_LANES = 4,
    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [PW-1:0]        rr_ptr,
    input  logic                 hold,
    output logic [NUM_LANES-1:0] grant
);

    // Stay on rr_ptr when allowed, else pick the first requester after it.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        grant = '0;
        found = 1'b0;
        idx   = '0;
        if (hold && req[rr_ptr]) begin
            grant[rr_ptr] = 1'b1;
        end else begin
            // Offsets 1..NUM_LANES: rr_ptr itself is visited last.
            for (int off = 1; off <= NUM_LANES; off++) begin
                idx = PW'((int'(rr_ptr) + off) % NUM_LANES);
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/phy_tx_scheduler.sv
// TX byte scheduler: sends the comma preamble after enable, then shares the
// serializer between lane FIFOs with burst-limited round-robin, filling
// idle cycles with commas.
module phy_tx_scheduler
    import phy_pkg::*;
#(
    parameter int         NUM_LANES   = 4,
    parameter int         ALIGN_COUNT = 4,
    parameter int         BURST       = 2,
    parameter logic [7:0] COMMA       = COMMA_BC
) (
    input  logic                   clk_4f,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_LANES-1:0]   req,
    input  logic [8*NUM_LANES-1:0] data_in,
    output logic [NUM_LANES-1:0]   grant,
    output logic [7:0]             data_out,
    output logic                   valid_out,
    output logic                   active_out,
    output logic                   err_comma
);

    localparam int PW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int ACW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
    localparam int BCW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [ACW-1:0] ALIGN_LAST = ACW'(ALIGN_COUNT - 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST - 1);
    localparam logic [PW-1:0]  PTR_RESET  = PW'(NUM_LANES - 1);

    state_t          state_q;
    logic [ACW-1:0]  align_cnt_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [BCW-1:0]  burst_cnt_q;
    logic [BCW-1:0]  burst_cnt_d;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            active_q;
    logic            err_q;

    logic [NUM_LANES-1:0] arb_grant;
    logic                 hold;
    logic                 running;
    logic                 sel_valid;
    logic [PW-1:0]        sel_idx;
    logic [7:0]           sel_byte;

    // The current owner may keep the lane until it has had BURST bytes.
    assign hold    = (burst_cnt_q < BURST_LAST);
    assign running = (state_q == ST_RUN) && enable;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .hold   (hold),
        .grant  (arb_grant)
    );

    // Grant (FIFO pop) only while the link is running.
    assign grant = running ? arb_grant : '0;

    // Encode the one-hot grant and fetch the winning lane's byte.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant[i]) sel_idx = PW'(i);
        end
        sel_valid = |grant;
        sel_byte  = lane_byte((8*MAX_LANES)'(data_in), 3'(sel_idx));
    end

    // Burst counter: count back-to-back grants to one lane, saturating at the
    // limit so a long single-requester run cannot wrap into a fresh burst.
    always_comb begin
        if (sel_idx != rr_ptr_q)           burst_cnt_d = '0;
        else if (burst_cnt_q == BURST_LAST) burst_cnt_d = burst_cnt_q;
        else                                burst_cnt_d = burst_cnt_q + 1'b1;
    end

    // Scheduler FSM with registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ALIGN;
            align_cnt_q <= '0;
            rr_ptr_q    <= PTR_RESET;
            burst_cnt_q <= '0;
            data_q      <= COMMA;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Defaults: idle comma, no pulse; overridden by a delivered byte.
            data_q  <= COMMA;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_ALIGN: begin
                    active_q <= 1'b0;
                    if (!enable) begin
                        align_cnt_q <= '0;
                    end else if (align_cnt_q == ALIGN_LAST) begin
                        align_cnt_q <= '0;
                        state_q     <= ST_RUN;
                    end else begin
                        align_cnt_q <= align_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_q     <= ST_ALIGN;
                        align_cnt_q <= '0;
                        active_q    <= 1'b0;
                    end else begin
                        active_q <= 1'b1;
                        if (sel_valid) begin
                            rr_ptr_q    <= sel_idx;
                            burst_cnt_q <= burst_cnt_d;
                            // A comma inside lane data is consumed but
                            // never forwarded; flag it instead.
                            if (sel_byte != COMMA) begin
                                data_q  <= sel_byte;
                                valid_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            burst_cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= ST_ALIGN;
            endcase
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign active_out = active_q;
    assign err_comma  = err_q;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Directed bench for phy_tx_scheduler (NUM_LANES=4, ALIGN_COUNT=4, BURST=2).
// Inputs change 1 ns after a rising edge; registered outputs are compared
// at that point, grant is compared 1 ns later once the new inputs settle.
module tb_phy_tx_scheduler;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        active_out;
    logic        err_comma;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_4f = ~clk_4f;

    phy_tx_scheduler #(
        .NUM_LANES   (4),
        .ALIGN_COUNT (4),
        .BURST       (2),
        .COMMA       (8'hBC)
    ) dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .data_in    (data_in),
        .grant      (grant),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active_out (active_out),
        .err_comma  (err_comma)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Registered outputs packed as {data_out, valid_out, active_out, err_comma}.
    task automatic check_out(input string tag, input logic [7:0] d, input logic v,
                             input logic a, input logic e);
        check(tag, {21'd0, data_out, valid_out, active_out, err_comma},
                   {21'd0, d, v, a, e});
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g);
        #1;
        check(tag, {28'd0, grant}, {28'd0, g});
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic set_lanes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        data_in = {b3, b2, b1, b0};
    endtask

    // Full-load round-robin expectations entering with rr_ptr=3 at its limit.
    logic [3:0] rr_grant [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [7:0] rr_data  [9] = '{8'h10, 8'h10, 8'h20, 8'h20, 8'h30,
                                 8'h30, 8'h40, 8'h40, 8'h10};

    // Watchdog: the directed sequence is a few hundred ns long.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        req     = 4'b0000;
        data_in = '0;
        #1;
        check_out("reset_outputs", 8'hBC, 1'b0, 1'b0, 1'b0);
        check("reset_grant", {28'd0, grant}, 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // enable low: alignment counter held, nothing moves.
        tick();
        tick();
        check_out("align_hold_disabled", 8'hBC, 1'b0, 1'b0, 1'b0);

        // Preamble: exactly four commas with active_out low.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("preamble_%0d", i), 8'hBC, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            check_grant($sformatf("idle_grant_%0d", i), 4'b0000);
            tick();
            check_out($sformatf("idle_run_%0d", i), 8'hBC, 1'b0, 1'b1, 1'b0);
        end

        // Lane 3 alone for two bytes, leaving its burst exhausted.
        req = 4'b1000;
        set_lanes(8'h00, 8'h00, 8'h00, 8'h77);
        check_grant("lane3_grant_a", 4'b1000);
        tick();
        check_out("lane3_byte_a", 8'h77, 1'b1, 1'b1, 1'b0);
        set_lanes(8'h00, 8'h00, 8'h00, 8'h78);
        check_grant("lane3_grant_b", 4'b1000);
        tick();
        check_out("lane3_byte_b", 8'h78, 1'b1, 1'b1, 1'b0);

        // All lanes requesting: pairs per lane, round-robin.
        req = 4'b1111;
        set_lanes(8'h10, 8'h20, 8'h30, 8'h40);
        for (int i = 0; i < 9; i++) begin
            check_grant($sformatf("rr_grant_%0d", i), rr_grant[i]);
            tick();
            check_out($sformatf("rr_byte_%0d", i), rr_data[i], 1'b1, 1'b1, 1'b0);
        end
        req = 4'b0000;
        check_grant("rr_idle_grant", 4'b0000);
        tick();
        check_out("rr_idle", 8'hBC, 1'b0, 1'b1, 1'b0);

        // Single requester: granted every cycle despite BURST=2.
        req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            set_lanes(8'h00, 8'h00, 8'hA0 + 8'(i), 8'h00);
            check_grant($sformatf("solo_grant_%0d", i), 4'b0100);
            tick();
            check_out($sformatf("solo_byte_%0d", i), 8'hA0 + 8'(i), 1'b1, 1'b1, 1'b0);
        end
        req = 4'b0000;
        check_grant("solo_idle_grant", 4'b0000);
        tick();
        check_out("solo_idle", 8'hBC, 1'b0, 1'b1, 1'b0);

        // Comma inside lane data: popped, dropped, flagged for one cycle.
        req = 4'b0010;
        set_lanes(8'h00, 8'hBC, 8'h00, 8'h00);
        check_grant("comma_grant", 4'b0010);
        tick();
        check_out("comma_dropped", 8'hBC, 1'b0, 1'b1, 1'b1);
        set_lanes(8'h00, 8'h55, 8'h00, 8'h00);
        check_grant("after_comma_grant", 4'b0010);
        tick();
        check_out("after_comma_byte", 8'h55, 1'b1, 1'b1, 1'b0);

        // Enable dropped for one cycle: back to a full fresh preamble.
        req    = 4'b1111;
        set_lanes(8'h10, 8'h20, 8'h30, 8'h40);
        enable = 1'b0;
        check_grant("disable_grant", 4'b0000);
        tick();
        check_out("disable_out", 8'hBC, 1'b0, 1'b0, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_grant($sformatf("realign_grant_%0d", i), 4'b0000);
            tick();
            check_out($sformatf("realign_%0d", i), 8'hBC, 1'b0, 1'b0, 1'b0);
        end
        // rr_ptr=1 with its burst spent survives realignment: lane 2 next.
        check_grant("resume_grant", 4'b0100);
        tick();
        check_out("resume_byte", 8'h30, 1'b1, 1'b1, 1'b0);

        // Reset between edges mid-burst: outputs clear without a clock.
        check_grant("preburst_grant", 4'b0100);
        reset = 1'b1;
        #1;
        check_out("async_reset_out", 8'hBC, 1'b0, 1'b0, 1'b0);
        check("async_reset_grant", {28'd0, grant}, 32'd0);
        tick();
        check_out("reset_held_out", 8'hBC, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_grant($sformatf("post_reset_grant_%0d", i), 4'b0000);
            tick();
            check_out($sformatf("post_reset_preamble_%0d", i), 8'hBC, 1'b0, 1'b0, 1'b0);
        end
        // After reset rr_ptr=3 with a fresh burst: lane 3 first, then lane 0.
        check_grant("post_reset_first_grant", 4'b1000);
        tick();
        check_out("post_reset_first_byte", 8'h40, 1'b1, 1'b1, 1'b0);
        check_grant("post_reset_second_grant", 4'b0001);
        tick();
        check_out("post_reset_second_byte", 8'h10, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
